runner_sprite: RTL and testbench

//  Pixel-generation stage directly downstream of hvsync_generator. Consumes CounterX/CounterY/inDisplayArea,

---
 rtl/runner_sprite_pkg.sv | 16 +
 rtl/runner_sprite_if.sv | 22 ++
 rtl/runner_sprite_btn_sync.sv | 30 +++
 rtl/runner_sprite.sv | 162 ++++++++++++++++
 tb/tb_runner_sprite.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/runner_sprite_pkg.sv
// Shared encodings and constants for the runner sprite pixel stage.
// Frame tick position, visible width and ground strip height live here.
package runner_sprite_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } state_t;

    localparam logic [9:0] TICK_X         = 10'h2FF;
    localparam logic [8:0] TICK_Y         = 9'd480;
    localparam int         VIS_W          = 640;
    localparam int         GROUND_STRIP_H = 8;

endpackage

// File: rtl/runner_sprite_if.sv
// Video bus between the sync generator side and the pixel stage.
// Streaming, no back-pressure: one counter position per clock in, one registered pixel colour out.
interface runner_sprite_if;

    logic [9:0] CounterX;
    logic [8:0] CounterY;
    logic       inDisplayArea;
    logic       vga_R;
    logic       vga_G;
    logic       vga_B;

    modport master (
        output CounterX, CounterY, inDisplayArea,
        input  vga_R, vga_G, vga_B
    );

    modport slave (
        input  CounterX, CounterY, inDisplayArea,
        output vga_R, vga_G, vga_B
    );

endinterface

// File: rtl/runner_sprite_btn_sync.sv
// Two-flop synchronizer for one asynchronous pushbutton.
// Both stages clear on asynchronous reset.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/runner_sprite.sv
// Runner sprite pixel stage: once-per-frame jump/move physics and a 1-cycle registered RGB path.
// Draws a yellow runner over a green ground strip on black.
module runner_sprite
    import runner_sprite_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int START_X  = 64,
    parameter int GROUND_Y = 400,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_V    = 12,
    parameter int H_STEP   = 2
) (
    input  logic            clk,
    input  logic            reset,
    runner_sprite_if.slave  vid,
    input  logic            btn_jump,
    input  logic            btn_left,
    input  logic            btn_right,
    output logic [9:0]      player_x,
    output logic [8:0]      player_y,
    output logic            airborne,
    output state_t          dbg_state
);

    localparam logic [10:0] STEP11   = 11'(H_STEP);
    localparam logic [10:0] XMAX11   = 11'(VIS_W - SPRITE_W);
    localparam logic [10:0] SW11     = 11'(SPRITE_W);
    localparam logic [9:0]  SH10     = 10'(SPRITE_H);
    localparam logic [9:0]  GY10     = 10'(GROUND_Y);
    localparam logic [9:0]  STRIP_LO = 10'(GROUND_Y + SPRITE_H);
    localparam logic [9:0]  STRIP_HI = 10'(GROUND_Y + SPRITE_H + GROUND_STRIP_H);
    localparam logic [4:0]  JV5      = 5'(JUMP_V);
    localparam logic [4:0]  GRAV5    = 5'(GRAVITY);
    localparam logic [4:0]  MAXV5    = 5'(MAX_V);

    logic jump_s, left_s, right_s;

    btn_sync u_sync_jump  (.clk(clk), .rst(reset), .din(btn_jump),  .dout(jump_s));
    btn_sync u_sync_left  (.clk(clk), .rst(reset), .din(btn_left),  .dout(left_s));
    btn_sync u_sync_right (.clk(clk), .rst(reset), .din(btn_right), .dout(right_s));

    state_t     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic [4:0] vel_q, vel_d;
    logic       armed_q, armed_d;
    logic       airborne_q, airborne_d;
    logic       r_q, r_d, g_q, g_d, b_q, b_d;

    logic        tick;
    logic [10:0] x11, cx11;
    logic [9:0]  y10, cy10, fall_sum;
    logic [5:0]  vel_inc;
    logic        hit_p, hit_g;

    assign tick = (vid.CounterX == TICK_X) && (vid.CounterY == TICK_Y);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        vel_d    = vel_q;
        armed_d  = armed_q;
        x11      = {1'b0, x_q};
        y10      = {1'b0, y_q};
        fall_sum = y10 + {5'd0, vel_q};
        vel_inc  = {1'b0, vel_q} + {1'b0, GRAV5};

        if (tick) begin
            // 11-bit arithmetic so the clamps below can never wrap.
            if (left_s && !right_s) begin
                x_d = (x11 >= STEP11) ? 10'(x11 - STEP11) : 10'd0;
            end else if (right_s && !left_s) begin
                x_d = (x11 + STEP11 >= XMAX11) ? XMAX11[9:0] : 10'(x11 + STEP11);
            end

            if (!jump_s) begin
                armed_d = 1'b1;
            end

            case (state_q)
                GROUND: begin
                    if (jump_s && armed_q) begin
                        vel_d   = JV5;
                        state_d = RISE;
                        armed_d = 1'b0;
                    end
                end
                RISE: begin
                    y_d = y_q - {4'd0, vel_q};
                    if (vel_q <= GRAV5) begin
                        vel_d   = 5'd0;
                        state_d = FALL;
                    end else begin
                        vel_d = vel_q - GRAV5;
                    end
                end
                FALL: begin
                    if (fall_sum >= GY10) begin
                        y_d     = GY10[8:0];
                        vel_d   = 5'd0;
                        state_d = GROUND;
                    end else begin
                        y_d   = fall_sum[8:0];
                        vel_d = (vel_inc > {1'b0, MAXV5}) ? MAXV5 : vel_inc[4:0];
                    end
                end
                default: state_d = GROUND;
            endcase
        end

        airborne_d = (state_d != GROUND);
    end

    always_comb begin
        cx11  = {1'b0, vid.CounterX};
        cy10  = {1'b0, vid.CounterY};
        hit_p = (cx11 >= x11) && (cx11 < x11 + SW11) &&
                (cy10 >= y10) && (cy10 < y10 + SH10);
        hit_g = (cy10 >= STRIP_LO) && (cy10 < STRIP_HI);
        r_d   = hit_p;
        g_d   = hit_p | hit_g;
        b_d   = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= GROUND;
            x_q        <= 10'(START_X);
            y_q        <= 9'(GROUND_Y);
            vel_q      <= 5'd0;
            armed_q    <= 1'b1;
            airborne_q <= 1'b0;
            r_q        <= 1'b0;
            g_q        <= 1'b0;
            b_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vel_q      <= vel_d;
            armed_q    <= armed_d;
            airborne_q <= airborne_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    // Gate with the already-registered display flag so blanking is always black.
    assign vid.vga_R = r_q & vid.inDisplayArea;
    assign vid.vga_G = g_q & vid.inDisplayArea;
    assign vid.vga_B = b_q & vid.inDisplayArea;

    assign player_x  = x_q;
    assign player_y  = y_q;
    assign airborne  = airborne_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_runner_sprite.sv
// Bench for runner_sprite: pixel vector table, hand-written jump/clamp/reset sequences,
// and randomized frames checked against a signed-velocity physics model.
module tb_runner_sprite;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_jump, btn_left, btn_right;
    logic [9:0] player_x;
    logic [8:0] player_y;
    logic       airborne;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    runner_sprite_if vid ();

    runner_sprite dut (
        .clk       (clk),
        .reset     (reset),
        .vid       (vid),
        .btn_jump  (btn_jump),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .player_x  (player_x),
        .player_y  (player_y),
        .airborne  (airborne),
        .dbg_state (dbg_state)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [19:0] exp_q[$];

    // Reference model: signed vertical velocity, negative means moving up.
    int mx, my, vy;
    bit in_air, armed;
    bit cj, cl, cr;

    typedef struct {
        int         cx;
        int         cy;
        bit         disp;
        logic [2:0] rgb;
    } pix_vec_t;

    pix_vec_t pv[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mx = 64; my = 400; vy = 0; in_air = 0; armed = 1;
    endtask

    task automatic model_tick(input bit j, input bit l, input bit r);
        if (l && !r) mx = (mx - 2 < 0) ? 0 : mx - 2;
        else if (r && !l) mx = (mx + 2 > 624) ? 624 : mx + 2;
        if (!in_air) begin
            if (j && armed) begin
                in_air = 1; vy = -12; armed = 0;
            end else if (!j) armed = 1;
        end else begin
            if (!j) armed = 1;
            if (vy < 0) begin
                my = my + vy;
                vy = vy + 1;
            end else if (my + vy >= 400) begin
                my = 400; vy = 0; in_air = 0;
            end else begin
                my = my + vy;
                vy = (vy + 1 > 12) ? 12 : vy + 1;
            end
        end
    endtask

    function automatic logic [2:0] pix_exp(input int cx, input int cy, input bit disp);
        bit hp, hg;
        hp = (cx >= mx) && (cx < mx + 16) && (cy >= my) && (cy < my + 16);
        hg = (cy >= 416) && (cy < 424);
        return disp ? {hp, hp | hg, 1'b0} : 3'b000;
    endfunction

    task automatic set_btn(input bit j, input bit l, input bit r);
        btn_jump = j; btn_left = l; btn_right = r;
        cj = j; cl = l; cr = r;
        cyc(3);
    endtask

    task automatic do_tick();
        vid.CounterX = 10'h2FF;
        vid.CounterY = 9'd480;
        cyc(1);
        vid.CounterX = 10'd0;
        vid.CounterY = 9'd0;
        model_tick(cj, cl, cr);
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_x"}, player_x, mx);
        check({tag, "_y"}, player_y, my);
        check({tag, "_air"}, airborne, in_air);
    endtask

    task automatic probe(input int cx, input int cy, input bit disp);
        vid.CounterX = 10'(cx);
        vid.CounterY = 9'(cy);
        vid.inDisplayArea = disp;
        cyc(1);
    endtask

    initial begin
        int launches;
        bit prev_air;
        int guard;

        pv[0]  = '{64, 400, 1, 3'b110};
        pv[1]  = '{79, 415, 1, 3'b110};
        pv[2]  = '{80, 400, 1, 3'b000};
        pv[3]  = '{63, 400, 1, 3'b000};
        pv[4]  = '{64, 420, 1, 3'b010};
        pv[5]  = '{300, 416, 1, 3'b010};
        pv[6]  = '{300, 423, 1, 3'b010};
        pv[7]  = '{300, 424, 1, 3'b000};
        pv[8]  = '{64, 400, 0, 3'b000};
        pv[9]  = '{64, 399, 1, 3'b000};
        pv[10] = '{100, 200, 1, 3'b000};

        reset = 1'b1;
        btn_jump = 0; btn_left = 0; btn_right = 0;
        cj = 0; cl = 0; cr = 0;
        vid.CounterX = 10'd0;
        vid.CounterY = 9'd0;
        vid.inDisplayArea = 1'b0;
        model_reset();
        cyc(3);
        reset = 1'b0;
        cyc(2);

        check("rst_x", player_x, 64);
        check("rst_y", player_y, 400);
        check("rst_air", airborne, 0);
        check("rst_rgb", {vid.vga_R, vid.vga_G, vid.vga_B}, 0);

        for (int i = 0; i < 11; i++) begin
            probe(pv[i].cx, pv[i].cy, pv[i].disp);
            check($sformatf("pix_tbl%0d", i), {vid.vga_R, vid.vga_G, vid.vga_B}, pv[i].rgb);
        end
        vid.inDisplayArea = 1'b0;

        // Single jump, button pulsed across the launch tick only.
        set_btn(1, 0, 0);
        do_tick();
        check("launch_air", airborne, 1);
        set_btn(0, 0, 0);
        for (int k = 1; k <= 30; k++) begin
            do_tick();
            check_pos($sformatf("jump%0d", k));
            if (k == 1) check("jump_y388", player_y, 388);
            if (k == 12) begin
                check("peak_y322", player_y, 322);
                check("peak_air", airborne, 1);
            end
            if (k == 26) begin
                check("landed_y", player_y, 400);
                check("landed_air", airborne, 0);
            end
        end

        // Held button must give exactly one jump.
        set_btn(1, 0, 0);
        launches = 0;
        prev_air = airborne;
        for (int k = 0; k < 60; k++) begin
            do_tick();
            check_pos($sformatf("hold%0d", k));
            if (airborne && !prev_air) launches++;
            prev_air = airborne;
        end
        check("hold_one_jump", launches, 1);
        set_btn(0, 0, 0);
        do_tick();
        set_btn(1, 0, 0);
        do_tick();
        check("rearm_launch", airborne, 1);
        set_btn(0, 0, 0);
        for (int k = 0; k < 30; k++) begin
            do_tick();
            check_pos($sformatf("rearm%0d", k));
        end

        // Horizontal clamps at both edges, and both buttons together.
        set_btn(0, 0, 1);
        guard = 0;
        while (mx < 622 && guard < 400) begin
            do_tick();
            check_pos("walk_r");
            guard++;
        end
        check("reach_622", player_x, 622);
        do_tick();
        check("clamp_r1", player_x, 624);
        do_tick();
        check("clamp_r2", player_x, 624);
        set_btn(0, 1, 0);
        for (int k = 0; k < 320; k++) do_tick();
        check("clamp_l", player_x, 0);
        do_tick();
        check("clamp_l2", player_x, 0);
        set_btn(0, 0, 1);
        do_tick();
        do_tick();
        check("step_to4", player_x, 4);
        set_btn(0, 1, 1);
        do_tick();
        check("both_hold", player_x, 4);

        // Left pressed and released with no tick in between: nothing moves.
        set_btn(0, 1, 0);
        cyc(10);
        check("no_tick_x", player_x, 4);
        set_btn(0, 0, 0);
        do_tick();
        check("after_tog_x", player_x, 4);

        // Randomized frames plus random pixel probes around the runner.
        for (int it = 0; it < 200; it++) begin
            int cx, cy;
            bit disp;
            logic [19:0] e;
            set_btn($urandom_range(0, 9) < 3, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            do_tick();
            exp_q.push_back({10'(mx), 9'(my), in_air});
            e = exp_q.pop_front();
            check($sformatf("rnd_pos%0d", it), {player_x, player_y, airborne}, e);
            cx = mx - 8 + int'($urandom_range(0, 32));
            if (cx < 0) cx = 0;
            if ($urandom_range(0, 1) == 1) cy = my - 4 + int'($urandom_range(0, 24));
            else cy = 410 + int'($urandom_range(0, 20));
            disp = ($urandom_range(0, 3) != 0);
            probe(cx, cy, disp);
            check($sformatf("rnd_pix%0d", it), {vid.vga_R, vid.vga_G, vid.vga_B}, pix_exp(cx, cy, disp));
            vid.inDisplayArea = 1'b0;
        end

        // Reset asserted mid-cycle while the runner is being drawn.
        set_btn(0, 0, 0);
        probe(mx, my, 1);
        check("pre_rst_rgb", {vid.vga_R, vid.vga_G, vid.vga_B}, 3'b110);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_rgb", {vid.vga_R, vid.vga_G, vid.vga_B}, 0);
        check("mid_rst_x", player_x, 64);
        check("mid_rst_y", player_y, 400);
        check("mid_rst_air", airborne, 0);
        model_reset();
        vid.CounterX = 10'd64;
        vid.CounterY = 9'd400;
        cyc(2);
        check("in_rst_rgb", {vid.vga_R, vid.vga_G, vid.vga_B}, 0);
        reset = 1'b0;
        cyc(1);
        check("post_rst_rgb", {vid.vga_R, vid.vga_G, vid.vga_B}, 3'b110);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
